// File: rtl/xor_byte_deserializer.sv
// xor_byte_deserializer: MSB-first serial word assembler that XORs each word with a latched key.
// Define XOR_KEY_ROTATE_EN to rotate the key left by 1 per word and reuse it across back-to-back words.
module xor_byte_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sdata,
    input  logic             tick,
    input  logic [WIDTH-1:0] key,
    output logic             cnt_en,
    output logic             busy,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready
);
    localparam int BW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] key_q, key_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [BW-1:0]    bit_idx_q, bit_idx_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] key_done;
    logic [WIDTH-1:0] key_b2b;

    assign word = {shreg_q[WIDTH-2:0], sdata};

`ifdef XOR_KEY_ROTATE_EN
    assign key_done = {key_q[WIDTH-2:0], key_q[WIDTH-1]};
    assign key_b2b  = key_q;
`else
    assign key_done = key_q;
    assign key_b2b  = key;
`endif

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        key_d     = key_q;
        dout_d    = dout_q;
        bit_idx_d = bit_idx_q;
        valid_d   = valid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d     = key;
                    bit_idx_d = '0;
                    shreg_d   = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    shreg_d   = word;
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == BW'(WIDTH - 1)) begin
                        dout_d  = word ^ key_q;
                        valid_d = 1'b1;
                        key_d   = key_done;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (valid_q && dout_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                    // start on the handshake cycle chains straight into the next word
                    if (start) begin
                        key_d     = key_b2b;
                        bit_idx_d = '0;
                        shreg_d   = '0;
                        state_d   = SHIFT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            key_q     <= '0;
            dout_q    <= '0;
            bit_idx_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            key_q     <= key_d;
            dout_q    <= dout_d;
            bit_idx_q <= bit_idx_d;
            valid_q   <= valid_d;
        end
    end

    // the counter restarts after each strobe, so enable drops on tick cycles
    assign cnt_en     = (state_q == SHIFT) & ~tick;
    assign busy       = (state_q != IDLE);
    assign dout       = dout_q;
    assign dout_valid = valid_q;
endmodule

// File: tb/tb_xor_byte_deserializer.sv
// tb_xor_byte_deserializer: directed bench for xor_byte_deserializer with a bit-period counter model.
// Expected second back-to-back word depends on XOR_KEY_ROTATE_EN.
module tb_xor_byte_deserializer;
    logic       clk, rst, start, sdata, tick, cnt_en, busy, dout_valid, dout_ready;
    logic [7:0] key, dout, tx, cnt, t_cnt;
    logic [2:0] bp;
    logic       xtick;
    int         tests, fails, n;

    xor_byte_deserializer #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .sdata(sdata), .tick(tick), .key(key),
        .cnt_en(cnt_en), .busy(busy), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bit-period counter: held at 0 while disabled, pulses when it reaches t_cnt
    always_ff @(posedge clk) cnt <= cnt_en ? cnt + 8'd1 : 8'd0;
    assign tick  = (cnt == t_cnt) | xtick;
    assign sdata = tx[~bp];

    always_ff @(posedge clk or posedge rst)
        if (rst) bp <= 3'd0;
        else if (tick && busy && !dout_valid) bp <= bp + 3'd1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!dout_valid && cycles < 200) begin
            step();
            cycles++;
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1; start = 0; key = 0; tx = 0; dout_ready = 0; xtick = 0; t_cnt = 8'd3;
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt_en", cnt_en, 0);
        step(); step(); rst = 0;

        // basic word
        tx = 8'h3C; key = 8'hA5; dout_ready = 1; start = 1;
        step(); start = 0;
        chk("basic_busy", busy, 1);
        chk("basic_cnt_en", cnt_en, 1);
        wait_valid(n);
        chk("basic_latency", n, 32);
        chk("basic_dout", dout, 8'h99);
        chk("basic_hold_cnt_en", cnt_en, 0);
        step();
        chk("basic_valid_1cyc", dout_valid, 0);
        chk("basic_busy_low", busy, 0);
        chk("basic_dout_kept", dout, 8'h99);

        // backpressure
        dout_ready = 0; start = 1;
        step(); start = 0;
        wait_valid(n);
        chk("bp_latency", n, 32);
        for (int i = 0; i < 10; i++) begin
            chk("bp_dout", dout, 8'h99);
            chk("bp_valid", dout_valid, 1);
            chk("bp_cnt_en", cnt_en, 0);
            step();
        end
        dout_ready = 1;
        step();
        chk("bp_valid_drop", dout_valid, 0);
        chk("bp_idle", busy, 0);

        // back-to-back, start held through SHIFT (ignored) and the handshake
        start = 1;
        step();
        wait_valid(n);
        chk("b2b_lat1", n, 32);
        chk("b2b_dout1", dout, 8'h99);
        step();
        chk("b2b_valid_drop", dout_valid, 0);
        chk("b2b_no_idle", busy, 1);
        start = 0;
        wait_valid(n);
        chk("b2b_lat2", n, 32);
`ifdef XOR_KEY_ROTATE_EN
        chk("b2b_dout2", dout, 8'h77);
`else
        chk("b2b_dout2", dout, 8'h99);
`endif
        step();
        chk("b2b_idle", busy, 0);

        // fast strobe
        t_cnt = 8'd0; tx = 8'hFF; key = 8'h0F; start = 1;
        step(); start = 0;
        wait_valid(n);
        chk("fast_latency", n, 8);
        chk("fast_dout", dout, 8'hF0);
        step();
        chk("fast_idle", busy, 0);

        // reset after 3 ticks
        t_cnt = 8'd3; tx = 8'h55; key = 8'h00; start = 1;
        step(); start = 0;
        repeat (12) step();
        #2 rst = 1;
        #1;
        chk("midrst_dout", dout, 0);
        chk("midrst_valid", dout_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cnt_en", cnt_en, 0);
        step(); rst = 0;
        tx = 8'h3C; key = 8'hA5; start = 1;
        step(); start = 0;
        wait_valid(n);
        chk("postrst_latency", n, 32);
        chk("postrst_dout", dout, 8'h99);
        step();

        // reset while holding a word
        dout_ready = 0; start = 1;
        step(); start = 0;
        wait_valid(n);
        chk("holdrst_valid_pre", dout_valid, 1);
        #2 rst = 1;
        #1;
        chk("holdrst_valid", dout_valid, 0);
        chk("holdrst_dout", dout, 0);
        step(); rst = 0; dout_ready = 1;

        // ticks in IDLE are ignored
        start = 1;
        step(); start = 0;
        wait_valid(n);
        chk("idle_pre_dout", dout, 8'h99);
        step();
        tx = 8'hFF; xtick = 1;
        repeat (3) step();
        xtick = 0;
        chk("idle_tick_dout", dout, 8'h99);
        chk("idle_tick_valid", dout_valid, 0);
        chk("idle_tick_busy", busy, 0);
        tx = 8'h00; key = 8'h5A; start = 1;
        step(); start = 0;
        wait_valid(n);
        chk("idle_next_latency", n, 32);
        chk("idle_next_dout", dout, 8'h5A);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
